// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types, size codes and load formatting for lsu_mem_ctrl
package mem_ctrl_pkg;

    localparam int ROW_W       = 15;
    localparam int BYTE_ADDR_W = 16;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    // state carried from the accept edge into the response cycle
    typedef struct packed {
        logic       valid;
        req_id_e    req;
        logic [2:0] funct3;
        logic       ba0;
        logic       err;
    } rsp_meta_t;

    // size and sign handling of a lane-ordered read word
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        case (f3)
            SZ_B:    r = {{24{w[7]}}, w[7:0]};
            SZ_BU:   r = {24'h0, w[7:0]};
            SZ_H:    r = {{16{w[15]}}, w[15:0]};
            SZ_HU:   r = {16'h0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_map.sv
// rtl/mem_lane_map.sv - byte address to even/odd RAM lane rows, write bytes and enables
module mem_lane_map
    import mem_ctrl_pkg::*;
(
    input  logic                   i_en,
    input  logic [BYTE_ADDR_W-1:0] i_ba,
    input  logic                   i_we,
    input  logic [1:0]             i_size,
    input  logic [31:0]            i_wdata,
    output logic [ROW_W-1:0]       o_addr_even_1,
    output logic [ROW_W-1:0]       o_addr_even_2,
    output logic [ROW_W-1:0]       o_addr_odd_1,
    output logic [ROW_W-1:0]       o_addr_odd_2,
    output logic [7:0]             o_data_even_1,
    output logic [7:0]             o_data_even_2,
    output logic [7:0]             o_data_odd_1,
    output logic [7:0]             o_data_odd_2,
    output logic                   o_we_even_1,
    output logic                   o_we_even_2,
    output logic                   o_we_odd_1,
    output logic                   o_we_odd_2
);

    logic [ROW_W-1:0] w_row;
    logic [ROW_W-1:0] w_row_p1;
    logic [ROW_W-1:0] w_row_p2;
    logic [3:0]       w_lane_we;

    // lane b0..b3 enables by store size; row arithmetic wraps at the top of memory
    always_comb begin
        w_row    = i_ba[BYTE_ADDR_W-1:1];
        w_row_p1 = w_row + ROW_W'(1);
        w_row_p2 = w_row + ROW_W'(2);
        case (i_size)
            2'b00:   w_lane_we = 4'b0001;
            2'b01:   w_lane_we = 4'b0011;
            2'b10:   w_lane_we = 4'b1111;
            default: w_lane_we = 4'b0000;
        endcase
        if (!(i_en && i_we)) begin
            w_lane_we = 4'b0000;
        end
    end

    // an odd start byte begins in the odd bank, so the lane order swaps banks
    always_comb begin
        o_addr_even_1 = '0;
        o_addr_even_2 = '0;
        o_addr_odd_1  = '0;
        o_addr_odd_2  = '0;
        o_data_even_1 = '0;
        o_data_even_2 = '0;
        o_data_odd_1  = '0;
        o_data_odd_2  = '0;
        o_we_even_1   = 1'b0;
        o_we_even_2   = 1'b0;
        o_we_odd_1    = 1'b0;
        o_we_odd_2    = 1'b0;
        if (i_en) begin
            if (!i_ba[0]) begin
                o_addr_even_1 = w_row;
                o_addr_odd_1  = w_row;
                o_addr_even_2 = w_row_p1;
                o_addr_odd_2  = w_row_p1;
                o_data_even_1 = i_wdata[7:0];
                o_data_odd_1  = i_wdata[15:8];
                o_data_even_2 = i_wdata[23:16];
                o_data_odd_2  = i_wdata[31:24];
                o_we_even_1   = w_lane_we[0];
                o_we_odd_1    = w_lane_we[1];
                o_we_even_2   = w_lane_we[2];
                o_we_odd_2    = w_lane_we[3];
            end else begin
                o_addr_odd_1  = w_row;
                o_addr_even_1 = w_row_p1;
                o_addr_odd_2  = w_row_p1;
                o_addr_even_2 = w_row_p2;
                o_data_odd_1  = i_wdata[7:0];
                o_data_even_1 = i_wdata[15:8];
                o_data_odd_2  = i_wdata[23:16];
                o_data_even_2 = i_wdata[31:24];
                o_we_odd_1    = w_lane_we[0];
                o_we_even_1   = w_lane_we[1];
                o_we_odd_2    = w_lane_we[2];
                o_we_even_2   = w_lane_we[3];
            end
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - fetch/LSU arbiter and sequencer for byte-banked memory (option MEM_CTRL_BOUNDS_EN)
module lsu_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_if_valid,
    output logic             o_if_ready,
    input  logic [31:0]      i_if_addr,
    output logic             o_if_rsp_valid,
    output logic [31:0]      o_if_rdata,
    output logic             o_if_err,
    input  logic             i_lsu_valid,
    output logic             o_lsu_ready,
    input  logic             i_lsu_we,
    input  logic [2:0]       i_lsu_funct3,
    input  logic [31:0]      i_lsu_addr,
    input  logic [31:0]      i_lsu_wdata,
    output logic             o_lsu_rsp_valid,
    output logic [31:0]      o_lsu_rdata,
    output logic             o_lsu_err,
    output logic [ROW_W-1:0] o_mem_addr_even_1,
    output logic [ROW_W-1:0] o_mem_addr_even_2,
    output logic [ROW_W-1:0] o_mem_addr_odd_1,
    output logic [ROW_W-1:0] o_mem_addr_odd_2,
    output logic [7:0]       o_mem_data_even_1,
    output logic [7:0]       o_mem_data_even_2,
    output logic [7:0]       o_mem_data_odd_1,
    output logic [7:0]       o_mem_data_odd_2,
    output logic             o_mem_we_even_1,
    output logic             o_mem_we_even_2,
    output logic             o_mem_we_odd_1,
    output logic             o_mem_we_odd_2,
    output logic             o_mem_lsu_addr,
    input  logic [31:0]      i_mem_rdata
);

    logic [3:0]  r_starve_cnt;
    rsp_meta_t   r_meta;
    logic        w_grant_if;
    logic        w_grant_lsu;
    logic        w_any;
    logic        w_we;
    logic        w_oob;
    logic [2:0]  w_funct3;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata_fmt;

    // LSU has priority unless fetch has lost STARVE_MAX times in a row; nothing granted in reset
    always_comb begin
        w_grant_if  = i_rst_n && i_if_valid &&
                      (!i_lsu_valid || (r_starve_cnt == 4'(STARVE_MAX)));
        w_grant_lsu = i_rst_n && i_lsu_valid && !w_grant_if;
        w_any       = w_grant_if || w_grant_lsu;
        o_if_ready  = w_grant_if;
        o_lsu_ready = w_grant_lsu;
    end

    // select the granted request; a fetch is always a word load
    always_comb begin
        w_addr   = '0;
        w_wdata  = '0;
        w_we     = 1'b0;
        w_funct3 = SZ_W;
        if (w_grant_lsu) begin
            w_addr   = i_lsu_addr;
            w_wdata  = i_lsu_wdata;
            w_we     = i_lsu_we;
            w_funct3 = i_lsu_funct3;
        end else if (w_grant_if) begin
            w_addr   = i_if_addr;
        end
    end

`ifdef MEM_CTRL_BOUNDS_EN
    assign w_oob = |w_addr[31:16];
`else
    logic w_unused_hi;
    assign w_oob       = 1'b0;
    assign w_unused_hi = ^w_addr[31:16];
`endif

    mem_lane_map u_lane_map (
        .i_en          (w_any),
        .i_ba          (w_addr[BYTE_ADDR_W-1:0]),
        .i_we          (w_we && !w_oob),
        .i_size        (w_funct3[1:0]),
        .i_wdata       (w_wdata),
        .o_addr_even_1 (o_mem_addr_even_1),
        .o_addr_even_2 (o_mem_addr_even_2),
        .o_addr_odd_1  (o_mem_addr_odd_1),
        .o_addr_odd_2  (o_mem_addr_odd_2),
        .o_data_even_1 (o_mem_data_even_1),
        .o_data_even_2 (o_mem_data_even_2),
        .o_data_odd_1  (o_mem_data_odd_1),
        .o_data_odd_2  (o_mem_data_odd_2),
        .o_we_even_1   (o_mem_we_even_1),
        .o_we_even_2   (o_mem_we_even_2),
        .o_we_odd_1    (o_mem_we_odd_1),
        .o_we_odd_2    (o_mem_we_odd_2)
    );

    // count consecutive cycles in which a valid fetch was passed over
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (i_if_valid && !w_grant_if) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // response metadata; lane order only follows issued reads
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '{valid: 1'b0, req: REQ_IF, funct3: SZ_W, ba0: 1'b0, err: 1'b0};
        end else begin
            r_meta.valid  <= w_any && !w_we;
            r_meta.req    <= w_grant_lsu ? REQ_LSU : REQ_IF;
            r_meta.funct3 <= w_funct3;
            r_meta.err    <= w_any && w_oob;
            if (w_any && !w_we) begin
                r_meta.ba0 <= w_addr[0];
            end
        end
    end

    // format the returned word and steer it to the requester; idle data reads 0
    always_comb begin
        w_rdata_fmt     = r_meta.err ? 32'h0 : fmt_load(r_meta.funct3, i_mem_rdata);
        o_if_rsp_valid  = r_meta.valid && (r_meta.req == REQ_IF);
        o_lsu_rsp_valid = r_meta.valid && (r_meta.req == REQ_LSU);
        o_if_rdata      = o_if_rsp_valid ? w_rdata_fmt : 32'h0;
        o_lsu_rdata     = o_lsu_rsp_valid ? w_rdata_fmt : 32'h0;
        o_mem_lsu_addr  = r_meta.ba0;
`ifdef MEM_CTRL_BOUNDS_EN
        o_if_err        = r_meta.err && (r_meta.req == REQ_IF);
        o_lsu_err       = r_meta.err && (r_meta.req == REQ_LSU);
`else
        o_if_err        = 1'b0;
        o_lsu_err       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - scoreboard bench for lsu_mem_ctrl with flat byte-array reference
module tb_lsu_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int SM = 3;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_if_valid = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic        i_lsu_valid = 1'b0;
    logic        i_lsu_we = 1'b0;
    logic [2:0]  i_lsu_funct3 = '0;
    logic [31:0] i_lsu_addr = '0;
    logic [31:0] i_lsu_wdata = '0;
    logic [31:0] i_mem_rdata;
    logic        o_if_ready, o_if_rsp_valid, o_if_err;
    logic [31:0] o_if_rdata;
    logic        o_lsu_ready, o_lsu_rsp_valid, o_lsu_err;
    logic [31:0] o_lsu_rdata;
    logic [14:0] o_mem_addr_even_1, o_mem_addr_even_2, o_mem_addr_odd_1, o_mem_addr_odd_2;
    logic [7:0]  o_mem_data_even_1, o_mem_data_even_2, o_mem_data_odd_1, o_mem_data_odd_2;
    logic        o_mem_we_even_1, o_mem_we_even_2, o_mem_we_odd_1, o_mem_we_odd_2;
    logic        o_mem_lsu_addr;

    lsu_mem_ctrl #(.STARVE_MAX(SM)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_if_valid(i_if_valid), .o_if_ready(o_if_ready), .i_if_addr(i_if_addr),
        .o_if_rsp_valid(o_if_rsp_valid), .o_if_rdata(o_if_rdata), .o_if_err(o_if_err),
        .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_we(i_lsu_we),
        .i_lsu_funct3(i_lsu_funct3), .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata),
        .o_lsu_rsp_valid(o_lsu_rsp_valid), .o_lsu_rdata(o_lsu_rdata), .o_lsu_err(o_lsu_err),
        .o_mem_addr_even_1(o_mem_addr_even_1), .o_mem_addr_even_2(o_mem_addr_even_2),
        .o_mem_addr_odd_1(o_mem_addr_odd_1), .o_mem_addr_odd_2(o_mem_addr_odd_2),
        .o_mem_data_even_1(o_mem_data_even_1), .o_mem_data_even_2(o_mem_data_even_2),
        .o_mem_data_odd_1(o_mem_data_odd_1), .o_mem_data_odd_2(o_mem_data_odd_2),
        .o_mem_we_even_1(o_mem_we_even_1), .o_mem_we_even_2(o_mem_we_even_2),
        .o_mem_we_odd_1(o_mem_we_odd_1), .o_mem_we_odd_2(o_mem_we_odd_2),
        .o_mem_lsu_addr(o_mem_lsu_addr), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int m_starve = 0;

    logic [7:0] ref_mem [0:65535];
    logic [7:0] ram_even [0:32767];
    logic [7:0] ram_odd  [0:32767];
    logic [7:0] q_e1, q_e2, q_o1, q_o2;

    typedef struct {
        logic        err_only;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t q_if[$];
    exp_t q_lsu[$];

    // two dual-port byte RAMs with registered read, plus the lane-order read mux
    always @(posedge i_clk) begin
        q_e1 <= ram_even[o_mem_addr_even_1];
        q_e2 <= ram_even[o_mem_addr_even_2];
        q_o1 <= ram_odd[o_mem_addr_odd_1];
        q_o2 <= ram_odd[o_mem_addr_odd_2];
        if (o_mem_we_even_1) ram_even[o_mem_addr_even_1] <= o_mem_data_even_1;
        if (o_mem_we_even_2) ram_even[o_mem_addr_even_2] <= o_mem_data_even_2;
        if (o_mem_we_odd_1)  ram_odd[o_mem_addr_odd_1]   <= o_mem_data_odd_1;
        if (o_mem_we_odd_2)  ram_odd[o_mem_addr_odd_2]   <= o_mem_data_odd_2;
    end
    assign i_mem_rdata = o_mem_lsu_addr ? {q_e2, q_o2, q_e1, q_o1} : {q_o2, q_e2, q_o1, q_e1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic oob(input logic [31:0] a);
`ifdef MEM_CTRL_BOUNDS_EN
        return a[31:16] != 16'h0;
`else
        return 1'b0;
`endif
    endfunction

    // little-endian load from the flat 64 KiB byte space with wraparound
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [15:0] ba);
        logic [31:0] w;
        logic [15:0] a1, a2, a3;
        a1 = ba + 16'd1;
        a2 = ba + 16'd2;
        a3 = ba + 16'd3;
        w = {ref_mem[a3], ref_mem[a2], ref_mem[a1], ref_mem[ba]};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // one cycle of stimulus: check readies against the priority rule, record expectations
    task automatic step(input logic ifv, input logic [31:0] ifa, input logic lv, input logic lwe,
                        input logic [2:0] f3, input logic [31:0] la, input logic [31:0] wd);
        logic g_if, g_lsu;
        int nbytes;
        logic [15:0] a;
        exp_t e;
        @(negedge i_clk);
        #1;
        i_if_valid = ifv; i_if_addr = ifa;
        i_lsu_valid = lv; i_lsu_we = lwe; i_lsu_funct3 = f3; i_lsu_addr = la; i_lsu_wdata = wd;
        #1;
        g_if  = ifv && (!lv || m_starve == SM);
        g_lsu = lv && !g_if;
        check("if_ready", 32'(o_if_ready), 32'(g_if));
        check("lsu_ready", 32'(o_lsu_ready), 32'(g_lsu));
        if (g_if) begin
            e.err_only = 1'b0;
            e.err      = oob(ifa);
            e.rdata    = e.err ? 32'h0 : ref_load(3'b010, ifa[15:0]);
            q_if.push_back(e);
        end
        if (g_lsu) begin
            if (lwe) begin
                if (oob(la)) begin
                    e.err_only = 1'b1; e.err = 1'b1; e.rdata = 32'h0;
                    q_lsu.push_back(e);
                end else begin
                    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
                    for (int i = 0; i < nbytes; i++) begin
                        a = la[15:0] + 16'(i);
                        ref_mem[a] = wd[8*i +: 8];
                    end
                end
            end else begin
                e.err_only = 1'b0;
                e.err      = oob(la);
                e.rdata    = e.err ? 32'h0 : ref_load(f3, la[15:0]);
                q_lsu.push_back(e);
            end
        end
        m_starve = (ifv && !g_if) ? m_starve + 1 : 0;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [15:0] lo, hi;
        lo = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7)))
                                         : 16'($urandom_range(0, 31));
        hi = 16'h0;
`ifdef MEM_CTRL_BOUNDS_EN
        if ($urandom_range(0, 7) == 0) hi = 16'($urandom_range(1, 65535));
`else
        hi = 16'($urandom);
`endif
        return {hi, lo};
    endfunction

    // monitor: pop and compare whenever a response or error strobe appears
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst_n) begin
            if (o_if_rsp_valid) begin
                if (q_if.size() == 0) begin
                    check("if_unexpected_rsp", 32'h1, 32'h0);
                end else begin
                    e = q_if.pop_front();
                    check("if_rdata", o_if_rdata, e.rdata);
                    check("if_err", 32'(o_if_err), 32'(e.err));
                end
            end else begin
                check("if_rdata_idle", o_if_rdata, 32'h0);
            end
            if (o_lsu_rsp_valid || o_lsu_err) begin
                if (q_lsu.size() == 0) begin
                    check("lsu_unexpected_rsp", 32'h1, 32'h0);
                end else begin
                    e = q_lsu.pop_front();
                    check("lsu_rsp_valid", 32'(o_lsu_rsp_valid), 32'(!e.err_only));
                    check("lsu_rdata", o_lsu_rdata, e.rdata);
                    check("lsu_err", 32'(o_lsu_err), 32'(e.err));
                end
            end else begin
                check("lsu_rdata_idle", o_lsu_rdata, 32'h0);
            end
        end
    end

    logic [2:0] ld_codes [0:4] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'($urandom);
        for (int r = 0; r < 32768; r++) begin
            ram_even[r] <= ref_mem[2*r];
            ram_odd[r]  <= ref_mem[2*r+1];
        end
        #2;
        // reset state
        check("rst_if_rsp_valid", 32'(o_if_rsp_valid), 32'h0);
        check("rst_lsu_rsp_valid", 32'(o_lsu_rsp_valid), 32'h0);
        check("rst_rdata", o_if_rdata | o_lsu_rdata, 32'h0);
        check("rst_err", 32'(o_if_err | o_lsu_err), 32'h0);
        check("rst_lsu_addr", 32'(o_mem_lsu_addr), 32'h0);
        check("rst_we", 32'({o_mem_we_even_1, o_mem_we_even_2, o_mem_we_odd_1, o_mem_we_odd_2}), 32'h0);
        check("rst_addr", 32'(o_mem_addr_even_1 | o_mem_addr_even_2 | o_mem_addr_odd_1 | o_mem_addr_odd_2), 32'h0);
        check("rst_starve", 32'(dut.r_starve_cnt), 32'h0);
        #20;
        i_rst_n = 1'b1;
        idle();

        // word store then load at an even, unaligned-to-word address
        step(1'b0, 32'h0, 1'b1, 1'b1, SZ_W, 32'h0002, 32'hDDCCBBAA);
        step(1'b0, 32'h0, 1'b1, 1'b0, SZ_W, 32'h0002, 32'h0);
        idle();
        check("lsu_addr_even", 32'(o_mem_lsu_addr), 32'h0);

        // sizes, sign extension and odd lane order
        step(1'b0, 32'h0, 1'b1, 1'b1, SZ_W, 32'h0000, 32'h80FF1234);
        step(1'b0, 32'h0, 1'b1, 1'b1, SZ_W, 32'h0004, 32'h00000011);
        step(1'b0, 32'h0, 1'b1, 1'b0, SZ_H, 32'h0003, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, SZ_B, 32'h0003, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, SZ_BU, 32'h0003, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, SZ_HU, 32'h0001, 32'h0);
        idle();
        check("lsu_addr_odd", 32'(o_mem_lsu_addr), 32'h1);

        // top-of-memory wrap
        step(1'b0, 32'h0, 1'b1, 1'b1, SZ_W, 32'h0000FFFE, 32'h44332211);
        check("wrap_even_2_row", 32'(o_mem_addr_even_2), 32'h0);
        check("wrap_odd_2_row", 32'(o_mem_addr_odd_2), 32'h0);
        check("wrap_even_1_row", 32'(o_mem_addr_even_1), 32'h7FFF);
        check("wrap_we", 32'({o_mem_we_even_1, o_mem_we_even_2, o_mem_we_odd_1, o_mem_we_odd_2}), 32'hF);
        step(1'b0, 32'h0, 1'b1, 1'b0, SZ_HU, 32'h0000, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, SZ_W, 32'h0000FFFE, 32'h0);

        // both requesters every cycle: starvation rule
        for (int k = 0; k < 8; k++)
            step(1'b1, 32'(4 * k), 1'b1, 1'b0, SZ_W, 32'(8 + k), 32'h0);

        // bounds / aliasing
        step(1'b0, 32'h0, 1'b1, 1'b0, SZ_W, 32'h00010000, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, SZ_W, 32'h00010000, 32'hA5A5A5A5);
`ifdef MEM_CTRL_BOUNDS_EN
        check("oob_store_we", 32'({o_mem_we_even_1, o_mem_we_even_2, o_mem_we_odd_1, o_mem_we_odd_2}), 32'h0);
`else
        check("alias_store_we", 32'({o_mem_we_even_1, o_mem_we_even_2, o_mem_we_odd_1, o_mem_we_odd_2}), 32'hF);
`endif
        step(1'b0, 32'h0, 1'b1, 1'b0, SZ_W, 32'h00000000, 32'h0);
        idle();

        // reset right after an accepted load
        step(1'b1, 32'h0, 1'b1, 1'b0, SZ_W, 32'h0010, 32'h0);
        step(1'b1, 32'h0, 1'b1, 1'b0, SZ_W, 32'h0014, 32'h0);
        step(1'b1, 32'h0, 1'b1, 1'b0, SZ_W, 32'h0018, 32'h0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        q_if.delete();
        q_lsu.delete();
        m_starve = 0;
        i_lsu_we = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(o_lsu_rsp_valid | o_if_rsp_valid), 32'h0);
        check("mid_rst_we", 32'({o_mem_we_even_1, o_mem_we_even_2, o_mem_we_odd_1, o_mem_we_odd_2}), 32'h0);
        check("mid_rst_ready", 32'({o_if_ready, o_lsu_ready}), 32'h0);
        @(negedge i_clk);
        #1;
        i_if_valid = 1'b0; i_lsu_valid = 1'b0; i_lsu_we = 1'b0;
        i_rst_n = 1'b1;
        #1;
        check("post_rst_starve", 32'(dut.r_starve_cnt), 32'h0);
        idle();
        for (int k = 0; k < 4; k++)
            step(1'b1, 32'(4 * k + 2), 1'b1, 1'b0, SZ_W, 32'(k + 1), 32'h0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic lwe;
            logic [2:0] f3;
            lwe = ($urandom_range(0, 2) == 0);
            f3  = lwe ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
            step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 3) != 0),
                 lwe, f3, rand_addr(), $urandom);
        end

        idle();
        idle();
        check("if_queue_drained", 32'(q_if.size()), 32'h0);
        check("lsu_queue_drained", 32'(q_lsu.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
